bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter W, default 10, giving the binary input width.
REQ-002 SHALL have parameter DIGITS, default 4, giving the number of BCD output digits; legal only when 10**DIGITS > 2**W - 1.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, rising edge active.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to convert bin_in; sampled only in IDLE.
REQ-006 SHALL have port bin_in, input, W bits: unsigned binary value, captured on the accepting edge.
REQ-007 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking a new bcd_out.
REQ-009 SHALL have port bcd_out, output, 4*DIGITS bits: packed BCD result, digit 0 (ones) in bits [3:0]; each nibble feeds one downstream BCD-to-7-segment decoder.

Function
REQ-010 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-011 In IDLE with start=1 at an edge: SHALL load bin_in into the binary shift register, clear the BCD scratch register, set the shift counter to W, and enter SHIFT.
REQ-012 In IDLE with start=0: SHALL remain in IDLE, holding all outputs.
REQ-013 Each SHIFT cycle SHALL first add 3 to every scratch digit >= 5, then shift {scratch, binary} left by one bit and decrement the counter (double-dabble).
REQ-014 After exactly W SHIFT cycles SHALL load bcd_out from scratch and enter DONE.
REQ-015 DONE SHALL last exactly one cycle and return to IDLE; done=1 only while in DONE.
REQ-016 Latency: start sampled at edge k -> bcd_out valid and done=1 from edge k+W+1 (11 cycles at W=10).
REQ-017 bcd_out SHALL hold its value from one done pulse until the next; it SHALL NOT change during SHIFT.
REQ-018 start while in SHIFT or DONE SHALL be ignored and not queued; bin_in changes after acceptance SHALL NOT affect the result.
REQ-019 Every bcd_out nibble SHALL be in range 0-9 for every legal bin_in, including all-ones.
REQ-020 The shift counter SHALL be $clog2(W+1) bits wide; add-3 correction SHALL be computed on 4-bit digits with no carry between digits.
REQ-021 W=1 SHALL be supported, giving latency 2.

Reset
REQ-022 While rst=1 at an edge: state SHALL go to IDLE, busy=0, done=0, bcd_out=0, and the scratch, shift and counter registers SHALL be cleared.
REQ-023 rst asserted mid-conversion SHALL abort it with no done pulse; a start on the first edge after rst deasserts SHALL be accepted.
REQ-024 rst SHALL take priority over start in the same cycle.

Structure
REQ-025 The state enum and constant BCD_DIGIT_W=4 SHALL live in shared package bcd_pkg, also used by the 7-segment decoder stage.
REQ-026 The per-digit conditional add-3 SHALL be a combinational sub-module bcd_add3 (4-bit in, 4-bit out), instantiated DIGITS times via generate.
REQ-027 All state SHALL be held in one clocked process; no latches and no combinational feedback.

Verification
REQ-028 rst high for 2 cycles, then low -> busy=0, done=0, bcd_out=16'h0000.
REQ-029 bin_in=1023, start pulse at edge k -> done=1 at edge k+11, bcd_out=16'h1023, busy=0 one cycle later.
REQ-030 Sweep bin_in from 0 to 1023 back-to-back (start re-asserted in IDLE) -> every result matches the reference decimal, all nibbles <= 9 (e.g. 999 -> 16'h0999, 0 -> 16'h0000).
REQ-031 bin_in=500, start; at k+3 assert start again with bin_in=7 -> single done at k+11, bcd_out=16'h0500, no second conversion.
REQ-032 bin_in=512, start; rst=1 at k+5 -> no done pulse, bcd_out=0; then bin_in=42, start -> bcd_out=16'h0042 after 11 cycles.
REQ-033 Hold start=1 continuously with bin_in=9 -> done pulses every 12 cycles, bcd_out=16'h0009 each time.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width and the converter FSM state type.
// Also imported by the downstream BCD-to-7-segment decoder stage.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Purely combinational; carries never cross into the neighbouring digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_DIGIT_W'(5)) begin
      o_digit = i_digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per clock.
// Result appears W+1 cycles after start is accepted and holds until the next result.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned W      = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [W-1:0]                  bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int unsigned CNT_W = $clog2(W + 1);
  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;

  state_e             r_state_q, w_state_d;
  logic [BCD_W-1:0]   r_scratch_q, w_scratch_d;
  logic [W-1:0]       r_bin_q, w_bin_d;
  logic [CNT_W-1:0]   r_cnt_q, w_cnt_d;
  logic [BCD_W-1:0]   r_bcd_q, w_bcd_d;

  logic [BCD_W-1:0]   w_corr;
  logic [BCD_W+W-1:0] w_cat;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Correct first, then shift the whole {scratch, binary} pair left by one.
  assign w_cat = {w_corr[BCD_W-2:0], r_bin_q, 1'b0};

  always_comb begin
    w_state_d   = r_state_q;
    w_scratch_d = r_scratch_q;
    w_bin_d     = r_bin_q;
    w_cnt_d     = r_cnt_q;
    w_bcd_d     = r_bcd_q;
    unique case (r_state_q)
      StIdle: begin
        if (start) begin
          w_bin_d     = bin_in;
          w_scratch_d = '0;
          w_cnt_d     = CNT_W'(W);
          w_state_d   = StShift;
        end
      end
      StShift: begin
        w_scratch_d = w_cat[W +: BCD_W];
        w_bin_d     = w_cat[W-1:0];
        w_cnt_d     = r_cnt_q - CNT_W'(1);
        // The final shift publishes its own result directly.
        if (r_cnt_q == CNT_W'(1)) begin
          w_bcd_d   = w_cat[W +: BCD_W];
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q   <= StIdle;
      r_scratch_q <= '0;
      r_bin_q     <= '0;
      r_cnt_q     <= '0;
      r_bcd_q     <= '0;
    end else begin
      r_state_q   <= w_state_d;
      r_scratch_q <= w_scratch_d;
      r_bin_q     <= w_bin_d;
      r_cnt_q     <= w_cnt_d;
      r_bcd_q     <= w_bcd_d;
    end
  end

  assign busy    = (r_state_q != StIdle);
  assign done    = (r_state_q == StDone);
  assign bcd_out = r_bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomized checks of bin2bcd_seq against a decimal-arithmetic model.
module tb_bin2bcd_seq;

  localparam int W      = 10;
  localparam int DIGITS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  bin_in;
  logic          busy;
  logic          done;
  logic [15:0]   bcd_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(
    .W      (W),
    .DIGITS (DIGITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int          rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  function automatic bit nibbles_ok(input logic [15:0] b);
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts v at edge k, then waits for done. lat is the number of edges after k
  // until done is seen high (W: done is high in the cycle ending at edge k+W+1).
  task automatic convert(input int v, output int lat, output logic [15:0] res);
    logic [15:0] prev;
    bin_in = W'(v);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bin_in = W'($urandom);
    prev   = bcd_out;
    lat    = -1;
    res    = 'x;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) begin
        lat = c;
        res = bcd_out;
        break;
      end
      check("hold_during_shift", 32'(bcd_out), 32'(prev));
    end
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  int          lat;
  logic [15:0] res;
  int          n_done;
  int          done_cyc[$];
  int          v;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd_out), 32'h0000);

    // All-ones input, latency check.
    convert(1023, lat, res);
    check("max_latency", 32'(lat), 32'(W));
    check("max_bcd", 32'(res), 32'h1023);
    check("max_hold", 32'(bcd_out), 32'h1023);

    // Full sweep, back to back.
    for (int i = 0; i < 1024; i++) begin
      convert(i, lat, res);
      check("sweep_latency", 32'(lat), 32'(W));
      check("sweep_bcd", 32'(res), 32'(ref_bcd(i)));
      check("sweep_nibbles", 32'(nibbles_ok(res)), 32'd1);
    end

    // Random values.
    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 1023));
      convert(v, lat, res);
      check("rand_bcd", 32'(res), 32'(ref_bcd(v)));
    end

    // Start during SHIFT is ignored and not queued.
    bin_in = 10'd500;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    bin_in = 10'd7;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n_done = 0;
    res    = '0;
    for (int c = 0; c < 30; c++) begin
      if (done) begin
        n_done++;
        res = bcd_out;
      end
      tick();
    end
    check("ignore_done_count", 32'(n_done), 32'd1);
    check("ignore_bcd", 32'(res), 32'h0500);
    check("ignore_final_bcd", 32'(bcd_out), 32'h0500);

    // Reset mid-conversion aborts with no done pulse.
    bin_in = 10'd512;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd_out), 32'h0000);
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) n_done++;
      tick();
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    convert(42, lat, res);
    check("after_abort_bcd", 32'(res), 32'h0042);
    check("after_abort_latency", 32'(lat), 32'(W));

    // Reset wins over start; start on first edge after reset is accepted.
    rst    = 1'b1;
    start  = 1'b1;
    bin_in = 10'd99;
    tick();
    check("rst_priority_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    start = 1'b0;
    check("post_rst_accept", 32'(busy), 32'd1);
    for (int c = 0; c < 15; c++) tick();
    check("post_rst_bcd", 32'(bcd_out), 32'h0099);

    // Continuous start: one result every W+2 cycles.
    bin_in = 10'd9;
    start  = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (done) begin
        done_cyc.push_back(c);
        check("cont_bcd", 32'(bcd_out), 32'h0009);
      end
    end
    start = 1'b0;
    check("cont_pulses", 32'(done_cyc.size() >= 3), 32'd1);
    for (int i = 1; i < done_cyc.size(); i++) begin
      check("cont_period", 32'(done_cyc[i] - done_cyc[i-1]), 32'(W + 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
